single_port_blockram_ctrl: RTL and testbench

//   Request front-end sitting directly upstream of single_port_blockram. Clears every set

---
 rtl/single_port_blockram_ctrl.sv | 127 ++++++++++++
 tb/tb_single_port_blockram_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/single_port_blockram_ctrl.sv
// Request front-end for single_port_blockram: clears the RAM after reset, then serves
// in-order read/write requests and returns read data through a one-entry response buffer.
module single_port_blockram_ctrl #(
  parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 64,
  parameter int NUMBER_SETS                 = 64,
  parameter int SET_PTR_WIDTH_IN_BITS       = $clog2(NUMBER_SETS)
) (
  input  logic                                   clk_in,
  input  logic                                   reset_in,
  input  logic                                   request_valid_in,
  input  logic                                   request_write_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       request_set_addr_in,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] request_element_in,
  output logic                                   request_ack_out,
  output logic                                   response_valid_out,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] response_element_out,
  input  logic                                   response_ack_in,
  output logic                                   ram_access_en_out,
  output logic                                   ram_write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]       ram_set_addr_out,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] ram_write_element_out,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] ram_read_element_in,
  output logic                                   init_done_out
);

  localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] LAST_SET = SET_PTR_WIDTH_IN_BITS'(NUMBER_SETS - 1);

  // SETTLE covers the edge on which the RAM samples the final clear write.
  typedef enum logic [1:0] {INIT, SETTLE, READY} state_t;

  state_t                             state;
  state_t                             state_next;
  logic [SET_PTR_WIDTH_IN_BITS-1:0]   clear_ctr;
  logic                               rd_issued;
  logic                               rd_wait;
  logic                               read_busy;
  logic                               accept;
  logic                               ram_access_next;
  logic                               ram_write_next;
  logic [SET_PTR_WIDTH_IN_BITS-1:0]   ram_addr_next;
  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] ram_data_next;

  assign read_busy       = rd_issued || rd_wait || response_valid_out;
  assign request_ack_out = (state == READY) && !read_busy;
  assign accept          = request_valid_in && request_ack_out;
  assign init_done_out   = (state == READY);

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) state <= INIT;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (clear_ctr == LAST_SET) state_next = SETTLE;
      SETTLE:  state_next = READY;
      READY:   state_next = READY;
      default: state_next = INIT;
    endcase
  end

  always_comb begin
    ram_access_next = 1'b0;
    ram_write_next  = 1'b0;
    ram_addr_next   = ram_set_addr_out;
    ram_data_next   = ram_write_element_out;
    case (state)
      INIT: begin
        ram_access_next = 1'b1;
        ram_write_next  = 1'b1;
        ram_addr_next   = clear_ctr;
        ram_data_next   = '0;
      end
      READY: begin
        if (accept) begin
          ram_access_next = 1'b1;
          ram_write_next  = request_write_in;
          ram_addr_next   = request_set_addr_in;
          ram_data_next   = request_element_in;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      ram_access_en_out     <= 1'b0;
      ram_write_en_out      <= 1'b0;
      ram_set_addr_out      <= '0;
      ram_write_element_out <= '0;
    end else begin
      ram_access_en_out     <= ram_access_next;
      ram_write_en_out      <= ram_write_next;
      ram_set_addr_out      <= ram_addr_next;
      ram_write_element_out <= ram_data_next;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in)
      clear_ctr <= '0;
    else if (state == INIT && clear_ctr != LAST_SET)
      clear_ctr <= clear_ctr + 1'b1;
  end

  // Read pipeline: RAM samples one edge after accept, buffer captures on the next.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      rd_issued            <= 1'b0;
      rd_wait              <= 1'b0;
      response_valid_out   <= 1'b0;
      response_element_out <= '0;
    end else begin
      rd_issued <= accept && !request_write_in;
      rd_wait   <= rd_issued;
      if (rd_wait) begin
        response_valid_out   <= 1'b1;
        response_element_out <= ram_read_element_in;
      end else if (response_valid_out && response_ack_in) begin
        response_valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_single_port_blockram_ctrl.sv
// Scoreboard bench for single_port_blockram_ctrl with a behavioural RAM attached to
// the ram_* port and a flat-array reference model of the set contents.
module tb_single_port_blockram_ctrl;

  localparam int DW = 64;
  localparam int NS = 64;
  localparam int AW = 6;

  logic          clk_in = 1'b0;
  logic          reset_in;
  logic          request_valid_in;
  logic          request_write_in;
  logic [AW-1:0] request_set_addr_in;
  logic [DW-1:0] request_element_in;
  logic          request_ack_out;
  logic          response_valid_out;
  logic [DW-1:0] response_element_out;
  logic          response_ack_in;
  logic          ram_access_en_out;
  logic          ram_write_en_out;
  logic [AW-1:0] ram_set_addr_out;
  logic [DW-1:0] ram_write_element_out;
  logic [DW-1:0] ram_read_element_in;
  logic          init_done_out;

  single_port_blockram_ctrl #(
    .SINGLE_ELEMENT_SIZE_IN_BITS(DW),
    .NUMBER_SETS(NS),
    .SET_PTR_WIDTH_IN_BITS(AW)
  ) dut (
    .clk_in(clk_in),
    .reset_in(reset_in),
    .request_valid_in(request_valid_in),
    .request_write_in(request_write_in),
    .request_set_addr_in(request_set_addr_in),
    .request_element_in(request_element_in),
    .request_ack_out(request_ack_out),
    .response_valid_out(response_valid_out),
    .response_element_out(response_element_out),
    .response_ack_in(response_ack_in),
    .ram_access_en_out(ram_access_en_out),
    .ram_write_en_out(ram_write_en_out),
    .ram_set_addr_out(ram_set_addr_out),
    .ram_write_element_out(ram_write_element_out),
    .ram_read_element_in(ram_read_element_in),
    .init_done_out(init_done_out)
  );

  always #5 clk_in = ~clk_in;

  // Behavioural single-port RAM sitting behind the controller.
  logic [DW-1:0] ram_mem [NS];
  always @(posedge clk_in) begin
    if (ram_access_en_out) begin
      if (ram_write_en_out) ram_mem[ram_set_addr_out] <= ram_write_element_out;
      else                  ram_read_element_in <= ram_mem[ram_set_addr_out];
    end
  end

  int            n_cmp = 0;
  int            n_err = 0;
  int            cycle = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model_mem [NS];
  bit            hold_ack = 1'b0;
  int            last_consume_cycle = 0;
  int            last_accept_cycle = 0;

  always @(posedge clk_in) cycle <= cycle + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("[TB] FAIL %s: timed out waiting for DUT", name);
  endtask

  // Issues one request starting at posedge+1; returns at posedge+1 after the accept edge.
  task automatic applyStimulus(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int waited = 0;
    request_valid_in    = 1'b1;
    request_write_in    = wr;
    request_set_addr_in = addr;
    request_element_in  = data;
    while (!request_ack_out && waited < 300) begin
      @(posedge clk_in); #1;
      waited++;
    end
    if (!request_ack_out) begin
      fail_now("accept");
      request_valid_in = 1'b0;
      return;
    end
    if (wr) model_mem[addr] = data;
    else    exp_q.push_back(model_mem[addr]);
    last_accept_cycle = cycle + 1;
    @(posedge clk_in); #1;
    check("ram_req", {ram_access_en_out, ram_write_en_out, ram_set_addr_out}, {1'b1, wr, addr});
    if (wr) check("ram_wdata", ram_write_element_out, data);
    request_valid_in = 1'b0;
  endtask

  // Monitor: drives response_ack_in and compares each consumed response with the scoreboard.
  bit            held = 1'b0;
  logic [DW-1:0] held_data;
  initial begin
    bit ack;
    response_ack_in = 1'b0;
    forever begin
      @(negedge clk_in);
      if (reset_in) begin
        response_ack_in = 1'b0;
        held = 1'b0;
        continue;
      end
      if (held && response_valid_out) check("resp_stable", response_element_out, held_data);
      ack = hold_ack ? 1'b0 : ($urandom_range(0, 3) != 0);
      response_ack_in = ack;
      if (response_valid_out && ack) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("[TB] FAIL resp_unexpected: got %h, expected no response", response_element_out);
        end else begin
          check("resp_data", response_element_out, exp_q.pop_front());
        end
        last_consume_cycle = cycle + 1;
      end
      held      = response_valid_out && !ack;
      held_data = response_element_out;
    end
  end

  task automatic checkOutput_reset_init();
    reset_in = 1'b1;
    exp_q.delete();
    foreach (model_mem[i]) model_mem[i] = '0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    reset_in = 1'b0;
    for (int k = 1; k <= NS + 1; k++) begin
      @(posedge clk_in); #1;
      if (k <= NS)
        check("init_clear",
              {init_done_out, request_ack_out, ram_access_en_out, ram_write_en_out, ram_set_addr_out, ram_write_element_out},
              {1'b0, 1'b0, 1'b1, 1'b1, AW'(k - 1), {DW{1'b0}}});
      else
        check("init_done", {init_done_out, ram_access_en_out, ram_write_en_out}, 3'b100);
    end
  endtask

  task automatic wait_drain();
    int waited = 0;
    while ((exp_q.size() != 0 || response_valid_out) && waited < 300) begin
      @(posedge clk_in); #1;
      waited++;
    end
    if (exp_q.size() != 0 || response_valid_out) fail_now("drain");
  endtask

  initial begin
    logic [DW-1:0] rnd;
    int            c0;
    int            waited;
    reset_in            = 1'b1;
    request_valid_in    = 1'b0;
    request_write_in    = 1'b0;
    request_set_addr_in = '0;
    request_element_in  = '0;
    #1;
    check("reset_state", {response_valid_out, init_done_out, request_ack_out, ram_access_en_out, ram_write_en_out}, 5'b0);

    checkOutput_reset_init();

    // Read of a freshly cleared set, with exact latency.
    applyStimulus(1'b0, 6'd63, 64'hDEAD_BEEF_0000_0001);
    check("busy_ack", request_ack_out, 1'b0);
    check("valid_T0", response_valid_out, 1'b0);
    @(posedge clk_in); #1;
    check("valid_T1", response_valid_out, 1'b0);
    check("idle_ram", {ram_access_en_out, ram_write_en_out}, 2'b00);
    @(posedge clk_in); #1;
    check("valid_T2", response_valid_out, 1'b1);

    // Write then read next cycle; then read with write data that must be ignored.
    applyStimulus(1'b1, 6'd63, 64'hFFFF_FFFF_0000_0000);
    applyStimulus(1'b0, 6'd63, 64'h0);
    applyStimulus(1'b0, 6'd63, 64'h0000_0000_FFFF_FFFF);
    applyStimulus(1'b0, 6'd63, 64'h0);
    wait_drain();

    // Back-to-back writes accept on consecutive cycles.
    c0 = cycle + 1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, AW'(i + 4), {$urandom, $urandom});
      check("b2b_write", last_accept_cycle, c0 + i);
    end

    // Held response blocks the next read until it is consumed.
    rnd = {$urandom, $urandom};
    applyStimulus(1'b1, 6'd7, rnd);
    hold_ack = 1'b1;
    applyStimulus(1'b0, 6'd63, 64'h0);
    fork
      applyStimulus(1'b0, 6'd7, 64'h0);
      begin
        for (int i = 0; i < 12; i++) begin
          check("held_ack", request_ack_out, 1'b0);
          @(posedge clk_in); #1;
        end
        hold_ack = 1'b0;
      end
    join
    check("reuse_cycle", last_accept_cycle, last_consume_cycle + 1);
    wait_drain();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk_in); #1;
      end
      applyStimulus($urandom_range(0, 1) == 1,
                    ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NS - 1)),
                    {$urandom, $urandom});
    end
    wait_drain();

    // Reset while a response is pending.
    applyStimulus(1'b1, 6'd63, 64'h1234_5678_9ABC_DEF0);
    hold_ack = 1'b1;
    applyStimulus(1'b0, 6'd63, 64'h0);
    waited = 0;
    while (!response_valid_out && waited < 20) begin
      @(posedge clk_in); #1;
      waited++;
    end
    check("pend_valid", response_valid_out, 1'b1);
    @(posedge clk_in); #3;
    reset_in = 1'b1;
    exp_q.delete();
    #1;
    check("reset_async", {response_valid_out, init_done_out}, 2'b00);
    hold_ack = 1'b0;
    checkOutput_reset_init();
    applyStimulus(1'b0, 6'd63, 64'h0);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
